// File: rtl/dmu_sii_sched_pkg.sv
// rtl/dmu_sii_sched_pkg.sv - shared types and constants for the SII inbound scheduler
package dmu_sii_sched_pkg;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  localparam int TAG_W   = 4;
  localparam int NTAGS   = 16;
  localparam int BEATS64 = 4;

  typedef struct packed {
    logic [127:0] hdr;
    logic [511:0] data;
    logic [63:0]  be;
    logic         wr;
    logic         len16;
    logic         byp;
  } pkt_t;

  function automatic logic [7:0] lane_parity(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

endpackage

// File: rtl/dmu_sii_tag_pool.sv
// rtl/dmu_sii_tag_pool.sv - 16-entry write-ack tag pool with lowest-free allocation
module dmu_sii_tag_pool
  import dmu_sii_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             any_free,
  input  logic             free_vld,
  input  logic [TAG_W-1:0] free_tag,
  output logic             done_vld,
  output logic [TAG_W-1:0] done_tag,
  output logic [4:0]       tags_free,
  output logic             tag_err
);

  logic [NTAGS-1:0] free_vec;
  logic [NTAGS-1:0] nxt_vec;
  logic             ack_ok;

  always_comb begin
    alloc_tag = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_tag = TAG_W'(i);
    end
  end

  assign any_free = |free_vec;
  assign ack_ok   = free_vld & ~free_vec[free_tag];

  // An acked tag only becomes visible to the encoder next cycle, so it never collides with alloc_tag.
  always_comb begin
    nxt_vec = free_vec;
    if (alloc)  nxt_vec[alloc_tag] = 1'b0;
    if (ack_ok) nxt_vec[free_tag]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_vec  <= '1;
      tags_free <= 5'(NTAGS);
      done_vld  <= 1'b0;
      done_tag  <= '0;
      tag_err   <= 1'b0;
    end else begin
      free_vec  <= nxt_vec;
      tags_free <= 5'($countones(nxt_vec));
      done_vld  <= ack_ok;
      done_tag  <= ack_ok ? free_tag : '0;
      tag_err   <= tag_err | (free_vld & free_vec[free_tag]);
    end
  end

endmodule

// File: rtl/dmu_sii_inb_sched.sv
// rtl/dmu_sii_inb_sched.sv - arbitrates ordered/bypass requests, tags writes, serialises onto the SII bus
module dmu_sii_inb_sched
  import dmu_sii_sched_pkg::*;
#(
  parameter int TAG_LSB    = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                  iol2clk,
  input  logic                  rst,
  input  logic [1:0]            src_req_vld,
  input  logic [1:0][127:0]     src_hdr,
  input  logic [1:0]            src_wr,
  input  logic [1:0]            src_len16,
  input  logic [1:0][511:0]     src_data,
  input  logic [1:0][63:0]      src_be,
  output logic [1:0]            src_gnt,
  output logic                  dmu_sii_hdr_vld,
  output logic                  dmu_sii_reqbypass,
  output logic                  dmu_sii_datareq,
  output logic                  dmu_sii_datareq16,
  output logic [127:0]          dmu_sii_data,
  output logic [7:0]            dmu_sii_parity,
  output logic [15:0]           dmu_sii_be,
  input  logic                  sii_dmu_wrack_vld,
  input  logic [TAG_W-1:0]      sii_dmu_wrack_tag,
  output logic                  wr_done_vld,
  output logic [TAG_W-1:0]      wr_done_tag,
  output logic [4:0]            tags_free,
  output logic                  tag_err
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t           state, nxt_state;
  logic [1:0]       beat, nxt_beat;
  pkt_t             pkt, pkt_nxt;
  logic [7:0]       starve;
  logic [1:0]       elig;
  logic             window, last_beat, ord_wins, sel, any_gnt, alloc, any_free;
  logic [TAG_W-1:0] alloc_tag;
  logic             n_hv, n_byp, n_dr, n_dr16;
  logic [127:0]     n_data, n_hdr;
  logic [15:0]      n_be;

  dmu_sii_tag_pool u_pool (
    .clk       (iol2clk),
    .rst       (rst),
    .alloc     (alloc),
    .alloc_tag (alloc_tag),
    .any_free  (any_free),
    .free_vld  (sii_dmu_wrack_vld),
    .free_tag  (sii_dmu_wrack_tag),
    .done_vld  (wr_done_vld),
    .done_tag  (wr_done_tag),
    .tags_free (tags_free),
    .tag_err   (tag_err)
  );

  assign last_beat = (state == DATA) && (pkt.len16 || beat == 2'(BEATS64 - 1));
  assign window    = (state == IDLE) || (state == HDR && !pkt.wr) || last_beat;
  assign elig[0]   = src_req_vld[0] & (~src_wr[0] | any_free);
  assign elig[1]   = src_req_vld[1] & (~src_wr[1] | any_free);
  assign ord_wins  = elig[0] & (~elig[1] | (starve >= STARVE_LIM));

  always_comb begin
    src_gnt = 2'b00;
    if (window) begin
      if (ord_wins)     src_gnt = 2'b01;
      else if (elig[1]) src_gnt = 2'b10;
    end
  end

  assign sel     = src_gnt[1];
  assign any_gnt = |src_gnt;
  assign alloc   = any_gnt & src_wr[sel];

  always_comb begin
    n_hdr = src_hdr[sel];
    if (src_wr[sel]) n_hdr[TAG_LSB +: TAG_W] = alloc_tag;
  end

  // Bus registers load from the post-grant packet so a new header can follow the last beat directly.
  always_comb begin
    pkt_nxt   = pkt;
    nxt_state = state;
    nxt_beat  = beat;
    n_hv      = 1'b0;
    n_byp     = 1'b0;
    n_dr      = 1'b0;
    n_dr16    = 1'b0;
    n_data    = '0;
    n_be      = '0;
    case (state)
      IDLE: nxt_state = IDLE;
      HDR: begin
        if (pkt.wr) begin
          nxt_state = DATA;
          nxt_beat  = 2'd0;
        end else begin
          nxt_state = IDLE;
        end
      end
      DATA: begin
        if (last_beat) nxt_state = IDLE;
        else           nxt_beat  = beat + 2'd1;
      end
      default: nxt_state = IDLE;
    endcase
    if (any_gnt) begin
      pkt_nxt   = '{hdr: n_hdr, data: src_data[sel], be: src_be[sel],
                    wr: src_wr[sel], len16: src_len16[sel], byp: sel};
      nxt_state = HDR;
    end
    case (nxt_state)
      HDR: begin
        n_hv   = 1'b1;
        n_byp  = pkt_nxt.byp;
        n_dr   = pkt_nxt.wr & ~pkt_nxt.len16;
        n_dr16 = pkt_nxt.wr & pkt_nxt.len16;
        n_data = pkt_nxt.hdr;
      end
      DATA: begin
        n_data = pkt_nxt.data[{nxt_beat, 7'd0} +: 128];
        n_be   = pkt_nxt.be[{nxt_beat, 4'd0} +: 16];
      end
      default: ;
    endcase
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      beat              <= '0;
      pkt               <= '0;
      dmu_sii_hdr_vld   <= 1'b0;
      dmu_sii_reqbypass <= 1'b0;
      dmu_sii_datareq   <= 1'b0;
      dmu_sii_datareq16 <= 1'b0;
      dmu_sii_data      <= '0;
      dmu_sii_parity    <= '0;
      dmu_sii_be        <= '0;
    end else begin
      state             <= nxt_state;
      beat              <= nxt_beat;
      pkt               <= pkt_nxt;
      dmu_sii_hdr_vld   <= n_hv;
      dmu_sii_reqbypass <= n_byp;
      dmu_sii_datareq   <= n_dr;
      dmu_sii_datareq16 <= n_dr16;
      dmu_sii_data      <= n_data;
      dmu_sii_parity    <= lane_parity(n_data);
      dmu_sii_be        <= n_be;
    end
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst)                       starve <= '0;
    else if (!elig[0] || src_gnt[0]) starve <= '0;
    else if (src_gnt[1])           starve <= starve + 8'd1;
  end

endmodule

// File: tb/tb_dmu_sii_inb_sched.sv
// tb/tb_dmu_sii_inb_sched.sv - scoreboard bench with a cycle-level reference model
module tb_dmu_sii_inb_sched;
  localparam int TAG_LSB    = 64;
  localparam int STARVE_MAX = 4;

  logic              iol2clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        src_req_vld = '0, src_wr = '0, src_len16 = '0;
  logic [1:0][127:0] src_hdr = '0;
  logic [1:0][511:0] src_data = '0;
  logic [1:0][63:0]  src_be = '0;
  logic [1:0]        src_gnt;
  logic              dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16;
  logic [127:0]      dmu_sii_data;
  logic [7:0]        dmu_sii_parity;
  logic [15:0]       dmu_sii_be;
  logic              sii_dmu_wrack_vld = 1'b0;
  logic [3:0]        sii_dmu_wrack_tag = '0;
  logic              wr_done_vld;
  logic [3:0]        wr_done_tag;
  logic [4:0]        tags_free;
  logic              tag_err;

  dmu_sii_inb_sched #(.TAG_LSB(TAG_LSB), .STARVE_MAX(STARVE_MAX)) dut (
    .iol2clk(iol2clk), .rst(rst), .src_req_vld(src_req_vld), .src_hdr(src_hdr),
    .src_wr(src_wr), .src_len16(src_len16), .src_data(src_data), .src_be(src_be),
    .src_gnt(src_gnt), .dmu_sii_hdr_vld(dmu_sii_hdr_vld), .dmu_sii_reqbypass(dmu_sii_reqbypass),
    .dmu_sii_datareq(dmu_sii_datareq), .dmu_sii_datareq16(dmu_sii_datareq16),
    .dmu_sii_data(dmu_sii_data), .dmu_sii_parity(dmu_sii_parity), .dmu_sii_be(dmu_sii_be),
    .sii_dmu_wrack_vld(sii_dmu_wrack_vld), .sii_dmu_wrack_tag(sii_dmu_wrack_tag),
    .wr_done_vld(wr_done_vld), .wr_done_tag(wr_done_tag), .tags_free(tags_free), .tag_err(tag_err)
  );

  always #5 iol2clk = ~iol2clk;

  typedef struct {
    int           cyc;
    logic         hv, byp, dr, dr16;
    logic [127:0] d;
    logic [15:0]  be;
  } bus_t;
  typedef struct {
    int         cyc;
    logic [3:0] tag;
  } done_t;

  int    vectors = 0, errors = 0, cyc = 0;
  bus_t  bq[$];
  done_t dq[$];

  logic [15:0] m_free = '1;
  int          m_starve = 0, m_next_ok = 0, last_gnt_cyc = -1;
  bit          m_err = 1'b0;
  logic [1:0]  m_gnt = '0;
  bit          rec = 1'b0;
  string       gseq = "";

  int         tgt[2] = '{0, 0};
  int         issued[2] = '{0, 0};
  int         kind[2] = '{0, 0};  // 0 read, 1 write, 2 random, 3 64 B write
  int         ack_pct = 0;
  int         fa_req = 0, fa_done = 0;
  logic [3:0] fa_tag = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_par(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = $countones(d[16*i +: 16]) % 2;
    return p;
  endfunction

  always @(posedge iol2clk) cyc = cyc + 1;

  // Reference model: grant window is tracked as the earliest cycle a new grant may happen.
  always @(negedge iol2clk) begin
    logic [1:0]   e, g;
    logic [15:0]  fr0;
    logic [127:0] h;
    int           s, t, nb;
    if (rst) begin
      m_free = '1; m_starve = 0; m_next_ok = 0; m_err = 1'b0; m_gnt = '0;
      bq.delete(); dq.delete();
    end else begin
      e[0] = src_req_vld[0] && (!src_wr[0] || m_free != 0);
      e[1] = src_req_vld[1] && (!src_wr[1] || m_free != 0);
      g = 2'b00;
      if (cyc >= m_next_ok) begin
        if (e[0] && (!e[1] || m_starve >= STARVE_MAX)) g = 2'b01;
        else if (e[1])                                 g = 2'b10;
      end
      chk("src_gnt", src_gnt, g);
      chk("tags_free", tags_free, $countones(m_free));
      chk("tag_err", tag_err, m_err);
      if (rec && src_gnt != 0) gseq = {gseq, src_gnt[1] ? "B" : "O"};
      if (!e[0] || g[0]) m_starve = 0;
      else if (g[1])     m_starve++;
      fr0 = m_free;
      if (g != 0) begin
        s = g[1] ? 1 : 0;
        h = src_hdr[s];
        if (src_wr[s]) begin
          t = 0;
          for (int i = 15; i >= 0; i--) if (m_free[i]) t = i;
          h[TAG_LSB +: 4] = 4'(t);
          m_free[t] = 1'b0;
        end
        bq.push_back('{cyc + 1, 1'b1, g[1], src_wr[s] & ~src_len16[s], src_wr[s] & src_len16[s], h, 16'h0});
        nb = !src_wr[s] ? 0 : (src_len16[s] ? 1 : 4);
        for (int k = 0; k < nb; k++)
          bq.push_back('{cyc + 2 + k, 1'b0, 1'b0, 1'b0, 1'b0, src_data[s][128*k +: 128], src_be[s][16*k +: 16]});
        m_next_ok = cyc + (!src_wr[s] ? 1 : (src_len16[s] ? 2 : 5));
        last_gnt_cyc = cyc;
      end
      if (sii_dmu_wrack_vld) begin
        if (fr0[sii_dmu_wrack_tag]) m_err = 1'b1;
        else begin
          m_free[sii_dmu_wrack_tag] = 1'b1;
          dq.push_back('{cyc + 1, sii_dmu_wrack_tag});
        end
      end
      m_gnt = g;
    end
  end

  // Monitor: consumes expected bus and completion entries as the DUT presents them.
  always @(negedge iol2clk) begin
    bus_t  x;
    done_t y;
    if (!rst) begin
      if (bq.size() > 0 && bq[0].cyc == cyc) begin
        x = bq.pop_front();
        chk("bus_flags", {dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16},
            {x.hv, x.byp, x.dr, x.dr16});
        chk("bus_data", dmu_sii_data, x.d);
        chk("bus_be", dmu_sii_be, x.be);
        chk("bus_parity", dmu_sii_parity, ref_par(x.d));
      end else begin
        chk("bus_idle", {dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16,
                         |dmu_sii_data, |dmu_sii_be, |dmu_sii_parity}, '0);
      end
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        y = dq.pop_front();
        chk("wr_done", {wr_done_vld, wr_done_tag}, {1'b1, y.tag});
      end else begin
        chk("wr_done_idle", wr_done_vld, 1'b0);
      end
    end
  end

  task automatic load(input int s);
    src_req_vld[s] = 1'b1;
    src_hdr[s]     = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 16; k++) src_data[s][32*k +: 32] = $urandom;
    src_be[s]      = {$urandom, $urandom};
    src_wr[s]      = (kind[s] == 0) ? 1'b0 : (kind[s] == 2) ? 1'($urandom % 2) : 1'b1;
    src_len16[s]   = (kind[s] == 3) ? 1'b0 : 1'($urandom % 2);
  endtask

  always @(posedge iol2clk) begin
    int  t0;
    bit  found;
    #1;
    if (rst) begin
      src_req_vld = '0;
      sii_dmu_wrack_vld = 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (m_gnt[s] || !src_req_vld[s]) begin
          if (issued[s] < tgt[s]) begin load(s); issued[s]++; end
          else src_req_vld[s] = 1'b0;
        end
      end
      sii_dmu_wrack_vld = 1'b0;
      if (fa_done != fa_req) begin
        sii_dmu_wrack_vld = 1'b1; sii_dmu_wrack_tag = fa_tag; fa_done = fa_req;
      end else if (m_free != '1 && $urandom_range(99) < ack_pct) begin
        t0 = $urandom_range(15); found = 0;
        for (int i = 0; i < 16; i++) begin
          if (!found && !m_free[(t0 + i) % 16]) begin
            found = 1; sii_dmu_wrack_vld = 1'b1; sii_dmu_wrack_tag = 4'((t0 + i) % 16);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge iol2clk);
      if (issued[0] == tgt[0] && issued[1] == tgt[1] && src_req_vld == 0 && bq.size() == 0 &&
          dq.size() == 0 && (ack_pct == 0 || m_free == '1)) return;
    end
    vectors++; errors++;
    $display("FAIL drain_timeout %s cyc=%0d", name, cyc);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge iol2clk);
  endtask

  task automatic force_ack(input logic [3:0] t);
    @(negedge iol2clk);
    fa_tag = t; fa_req++;
  endtask

  initial begin
    int g0;
    repeat (3) @(posedge iol2clk);
    #2;
    chk("rst_bus", {dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16,
                    dmu_sii_data, dmu_sii_parity, dmu_sii_be}, '0);
    chk("rst_done", {wr_done_vld, wr_done_tag, tag_err, src_gnt}, '0);
    chk("rst_tags_free", tags_free, 5'd16);
    @(posedge iol2clk); #2; rst = 1'b0;

    @(negedge iol2clk); kind[0] = 3; tgt[0] += 1; wait_drain("single_write");

    @(negedge iol2clk); rec = 1; kind[0] = 0; kind[1] = 0; tgt[0] += 12; tgt[1] += 12;
    wait_drain("reads"); rec = 0;
    vectors++;
    if (gseq.len() < 10 || gseq.substr(0, 9) != "BBBBOBBBBO") begin
      errors++; $display("FAIL gnt_seq got=%s want=BBBBOBBBBO", gseq);
    end

    @(negedge iol2clk); kind[0] = 1; tgt[0] += 16;
    for (int i = 0; i < 200 && !(issued[0] == tgt[0] && m_free == 0); i++) @(negedge iol2clk);
    chk("pool_full", tags_free, 5'd0);
    kind[1] = 0; tgt[1] += 3; tgt[0] += 1;
    wait_cycles(10);
    force_ack(4'd5);
    wait_cycles(12);
    tgt[0] += 1;
    wait_cycles(5);
    force_ack(4'd3);
    wait_cycles(12);
    ack_pct = 100; wait_drain("full_pool"); ack_pct = 0;

    @(negedge iol2clk); kind[0] = 2; kind[1] = 2; ack_pct = 40; tgt[0] += 40; tgt[1] += 40;
    wait_drain("random"); ack_pct = 100; wait_drain("random_acks"); ack_pct = 0;

    force_ack(4'd9);
    wait_cycles(5);
    chk("tag_err_sticky", tag_err, 1'b1);

    @(negedge iol2clk); kind[0] = 3; g0 = last_gnt_cyc; tgt[0] += 1;
    for (int i = 0; i < 30 && !(last_gnt_cyc != g0 && cyc == last_gnt_cyc + 4); i++) @(posedge iol2clk);
    #2; rst = 1'b1; #1;
    chk("midrst_bus", {dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16,
                       dmu_sii_data, dmu_sii_parity, dmu_sii_be}, '0);
    chk("midrst_tags", {tags_free, tag_err}, {5'd16, 1'b0});
    repeat (2) @(posedge iol2clk);
    #2; rst = 1'b0;
    @(negedge iol2clk); tgt[0] += 1; wait_drain("post_rst");
    ack_pct = 100; wait_drain("final"); ack_pct = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/dmu_sii_inb_sched.md
# dmu_sii_inb_sched

Inbound request scheduler between the DMU transaction sources and the SII inbound port. It accepts requests from two sources, ordered and bypass, and arbitrates between them. It inserts a write-ack tag from a 16-entry pool into each write header, then serialises header and payload beats onto the `dmu_sii_*` bus. It returns tags to the pool on `sii_dmu_wrack_vld`.

## Interface
Parameters:
- `TAG_LSB`, 64: bit position of the 4-bit write tag inside the 128-bit header.
- `STARVE_MAX`, 4: consecutive bypass grants allowed while ordered is waiting.

Ports:
- `iol2clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `src_req_vld` in 2: request valid; [0] is ordered, [1] is bypass.
- `src_hdr` in 2x128: header per source.
- `src_wr` in 2: request carries a payload.
- `src_len16` in 2: payload is 16 B (1 beat); otherwise 64 B (4 beats).
- `src_data` in 2x512: payload, beat k = bits [128k+127:128k].
- `src_be` in 2x64: byte enables, beat k = bits [16k+15:16k].
- `src_gnt` out 2: one-hot accept pulse, combinational.
- `dmu_sii_hdr_vld` out 1: header cycle.
- `dmu_sii_reqbypass` out 1: header is from the bypass source.
- `dmu_sii_datareq` out 1: header announces 64 B payload.
- `dmu_sii_datareq16` out 1: header announces 16 B payload.
- `dmu_sii_data` out 128: header or payload beat.
- `dmu_sii_parity` out 8: even parity per 16-bit lane.
- `dmu_sii_be` out 16: byte enables; 0 on header cycles.
- `sii_dmu_wrack_vld` in 1: write-ack strobe.
- `sii_dmu_wrack_tag` in 4: tag being acknowledged.
- `wr_done_vld` out 1: write completion to the DMU, registered.
- `wr_done_tag` out 4: completed tag.
- `tags_free` out 5: number of free tags (0..16).
- `tag_err` out 1: sticky; set when an ack arrives for a tag that is not outstanding.

## Operation
- State machine states:
  - IDLE: no packet on the bus.
  - HDR: header cycle on the bus.
  - DATA: payload beats on the bus; a beat counter runs 0..3.
- Eligibility:
  - A source is eligible when `src_req_vld` is set, and additionally, for writes, when at least one tag is free.
  - A read never waits for tags.
- Grant window: a grant may be given in IDLE, in HDR for a read, or in the last DATA beat. This allows back-to-back packets with no idle cycle.
- Priority:
  - Bypass wins by default.
  - If ordered has been eligible and lost `STARVE_MAX` consecutive times, ordered wins the next arbitration and the counter clears.
  - The counter also clears on any ordered grant, and when ordered is not eligible.
- On grant, the block latches the header, payload, byte enables, wr/len16 and source id into an internal packet buffer. The source may change its inputs from the next cycle.
- Tags:
  - A write allocates the lowest-numbered free tag.
  - That tag overwrites `hdr[TAG_LSB+3:TAG_LSB]`; read headers pass unchanged.
- Header cycle outputs:
  - `dmu_sii_datareq` = wr & !len16.
  - `dmu_sii_datareq16` = wr & len16.
  - `dmu_sii_reqbypass` = source id.
- Parity: `parity[i] = ^data[16i+15:16i]`, computed on every cycle in which header or data is driven.
- Write ack:
  - `sii_dmu_wrack_vld` with an outstanding tag frees that tag. One cycle later it produces `wr_done_vld`/`wr_done_tag`.
  - An ack for a tag that is not outstanding sets `tag_err`, leaves the pool unchanged and produces no `wr_done`.
- Simultaneous allocation and free:
  - When an ack and an allocation fall in the same cycle, the freed tag is not allocatable until the next cycle.
  - `tags_free` reflects both changes in the following cycle.

## Timing
- All `dmu_sii_*` outputs and `wr_done_*` are registered. `src_gnt` is combinational from `src_req_vld` and the pool state.
- Reset values: every output is 0, except `tags_free` = 16. The pool is all free, the starvation counter is 0, the state is IDLE and `tag_err` is cleared.
- Reset asserted mid-packet aborts the packet: the bus goes to 0 immediately (asynchronously) and allocated tags are returned.
- Latencies, with grant in cycle N:
  - Header appears at N+1.
  - 64 B payload beats appear at N+2..N+5, with the next grant possible at N+5.
  - 16 B payload beat appears at N+2, with the next grant possible at N+2.
  - A read's next grant is possible at N+1.
- Outside header and data cycles, data/parity/be/flags are driven to 0.

## Structure
- Package `dmu_sii_sched_pkg`:
  - state enum {IDLE, HDR, DATA};
  - `TAG_W=4`, `NTAGS=16`, `BEATS64=4`;
  - packet-buffer struct (hdr, data, be, wr, len16, byp).
- Sub-module `dmu_sii_tag_pool`: 16-bit free vector with a lowest-set priority encoder, alloc/free ports, `tags_free` count and the `tag_err` check.

## Test plan
- Single 64 B write from ordered, pool empty of allocations → header at N+1 with tag 0 at `TAG_LSB`, `datareq`=1, `reqbypass`=0; 4 beats with correct be and parity; `tags_free`=15.
- Both sources requesting reads continuously, `STARVE_MAX`=4 → grant sequence B,B,B,B,O,B,B,B,B,O; headers back-to-back with no gaps.
- 16 writes with no acks → tags 0..15 are used and `tags_free`=0. A further write stalls while a bypass read is still granted. An ack for tag 5 lets the stalled write get tag 5 one cycle later.
- Ack for tag 3 in the same cycle as a write grant, with only tag 3 otherwise freeable → grant waits, tag 3 is allocated the next cycle, and `wr_done_tag`=3 appears the cycle after the ack.
- Ack for tag 9 while tag 9 is free → `tag_err`=1 and stays 1, pool unchanged, no `wr_done`.
- `rst` asserted during beat 2 of a 64 B write → all outputs 0 immediately; after release `tags_free`=16 and the first new write gets tag 0.
